// File: rtl/writeback_stage.sv
// Final RV64 pipeline stage: picks ALU / extended load / PC+4 and drives the register-file write port.
// Latency: 1 cycle after accept for ALU and PC+4; 1 cycle after DMEM_RVALID for loads.
// Backpressure: WB_READY is low for the whole time a load is outstanding, and high in IDLE (including during reset).
module writeback_stage #(
    parameter int XLEN         = 64,
    parameter int LOAD_TIMEOUT = 255
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            MEM_V,
    output logic            WB_READY,
    input  logic [4:0]      MEM_DR,
    input  logic            MEM_REG_WE,
    input  logic [1:0]      MEM_WB_SEL,
    input  logic [2:0]      MEM_LD_FUNCT3,
    input  logic [XLEN-1:0] MEM_ALU_RESULT,
    input  logic [XLEN-1:0] MEM_PC,
    input  logic [XLEN-1:0] DMEM_RDATA,
    input  logic            DMEM_RVALID,
    output logic [4:0]      DR,
    output logic [XLEN-1:0] WB_DATA,
    output logic            ST_REG,
    output logic            WB_V,
    output logic [63:0]     INSTRET,
    output logic            LOAD_ERR
);

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } state_t;

    state_t state, state_nxt;

    // Fields of the outstanding load, held while waiting for data memory
    logic [4:0]  ld_dr;
    logic        ld_we;
    logic [2:0]  ld_funct3;
    logic [2:0]  ld_off;
    logic [15:0] tmo_cnt;
    logic [16:0] tmo_cnt_inc;

    logic            accept;
    logic            load_accept;
    logic            retire;
    logic            wr_en;
    logic            timeout;
    logic [4:0]      wr_dr;
    logic [XLEN-1:0] wr_data;
    logic [XLEN-1:0] ld_shifted;
    logic [XLEN-1:0] ld_ext;

    assign WB_READY    = (state == IDLE);
    assign accept      = MEM_V && WB_READY;
    assign load_accept = accept && (MEM_WB_SEL == 2'd1);
    assign tmo_cnt_inc = {1'b0, tmo_cnt} + 17'd1;

    // Byte-align the returned doubleword to the load address, then extend per funct3
    always_comb begin
        ld_shifted = DMEM_RDATA >> {ld_off, 3'b000};
        ld_ext     = ld_shifted;
        case (ld_funct3)
            3'b000:  ld_ext = {{(XLEN-8){ld_shifted[7]}},   ld_shifted[7:0]};
            3'b001:  ld_ext = {{(XLEN-16){ld_shifted[15]}}, ld_shifted[15:0]};
            3'b010:  ld_ext = {{(XLEN-32){ld_shifted[31]}}, ld_shifted[31:0]};
            3'b100:  ld_ext = {{(XLEN-8){1'b0}},  ld_shifted[7:0]};
            3'b101:  ld_ext = {{(XLEN-16){1'b0}}, ld_shifted[15:0]};
            3'b110:  ld_ext = {{(XLEN-32){1'b0}}, ld_shifted[31:0]};
            default: ld_ext = ld_shifted;
        endcase
    end

    // Next state and the retire decision for this cycle
    always_comb begin
        state_nxt = state;
        retire    = 1'b0;
        wr_en     = 1'b0;
        timeout   = 1'b0;
        wr_dr     = MEM_DR;
        wr_data   = MEM_ALU_RESULT;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (MEM_WB_SEL == 2'd1) begin
                        state_nxt = WAIT_LOAD;
                    end else begin
                        retire  = 1'b1;
                        wr_en   = MEM_REG_WE && (MEM_DR != 5'd0);
                        wr_dr   = MEM_DR;
                        wr_data = (MEM_WB_SEL == 2'd2) ? (MEM_PC + XLEN'(4)) : MEM_ALU_RESULT;
                    end
                end
            end
            WAIT_LOAD: begin
                if (DMEM_RVALID) begin
                    retire    = 1'b1;
                    wr_en     = ld_we && (ld_dr != 5'd0);
                    wr_dr     = ld_dr;
                    wr_data   = ld_ext;
                    state_nxt = IDLE;
                end else if (tmo_cnt_inc == 17'(LOAD_TIMEOUT)) begin
                    // Abandoned load still retires so the pipeline keeps moving, but writes nothing
                    retire    = 1'b1;
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Capture load context on accept; count cycles spent waiting for data
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            ld_dr     <= 5'd0;
            ld_we     <= 1'b0;
            ld_funct3 <= 3'd0;
            ld_off    <= 3'd0;
            tmo_cnt   <= 16'd0;
        end else if (load_accept) begin
            ld_dr     <= MEM_DR;
            ld_we     <= MEM_REG_WE;
            ld_funct3 <= MEM_LD_FUNCT3;
            ld_off    <= MEM_ALU_RESULT[2:0];
            tmo_cnt   <= 16'd0;
        end else if (state == WAIT_LOAD && !DMEM_RVALID) begin
            tmo_cnt   <= tmo_cnt_inc[15:0];
        end
    end

    // Register-file write port and retire bookkeeping; DR/WB_DATA only move on a real write
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            DR       <= 5'd0;
            WB_DATA  <= '0;
            ST_REG   <= 1'b0;
            WB_V     <= 1'b0;
            INSTRET  <= 64'd0;
            LOAD_ERR <= 1'b0;
        end else begin
            WB_V   <= retire;
            ST_REG <= wr_en;
            if (wr_en) begin
                DR      <= wr_dr;
                WB_DATA <= wr_data;
            end
            if (retire)  INSTRET  <= INSTRET + 64'd1;
            if (timeout) LOAD_ERR <= 1'b1;
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: driver pushes expected retires, a negedge monitor pops and compares.
module tb_writeback_stage;

    logic        CLK = 1'b0;
    logic        reset;
    logic        MEM_V;
    logic        WB_READY;
    logic [4:0]  MEM_DR;
    logic        MEM_REG_WE;
    logic [1:0]  MEM_WB_SEL;
    logic [2:0]  MEM_LD_FUNCT3;
    logic [63:0] MEM_ALU_RESULT;
    logic [63:0] MEM_PC;
    logic [63:0] DMEM_RDATA;
    logic        DMEM_RVALID;
    logic [4:0]  DR;
    logic [63:0] WB_DATA;
    logic        ST_REG;
    logic        WB_V;
    logic [63:0] INSTRET;
    logic        LOAD_ERR;

    writeback_stage #(.XLEN(64), .LOAD_TIMEOUT(8)) dut (
        .CLK(CLK), .reset(reset), .MEM_V(MEM_V), .WB_READY(WB_READY),
        .MEM_DR(MEM_DR), .MEM_REG_WE(MEM_REG_WE), .MEM_WB_SEL(MEM_WB_SEL),
        .MEM_LD_FUNCT3(MEM_LD_FUNCT3), .MEM_ALU_RESULT(MEM_ALU_RESULT), .MEM_PC(MEM_PC),
        .DMEM_RDATA(DMEM_RDATA), .DMEM_RVALID(DMEM_RVALID), .DR(DR), .WB_DATA(WB_DATA),
        .ST_REG(ST_REG), .WB_V(WB_V), .INSTRET(INSTRET), .LOAD_ERR(LOAD_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        st;
        logic [4:0]  dr;
        logic [63:0] data;
        logic [63:0] instret;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [63:0] exp_instret = 64'd0;
    logic        exp_err     = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic st, input logic [4:0] dr, input logic [63:0] data);
        exp_t e;
        exp_instret = exp_instret + 64'd1;
        e.st = st; e.dr = dr; e.data = data; e.instret = exp_instret; e.err = exp_err;
        exp_q.push_back(e);
    endtask

    // Monitor: every retire must match the oldest expected entry
    always @(negedge CLK) begin
        if (reset === 1'b1) begin
            if (ST_REG && !WB_V) begin
                failures++;
                $display("FAIL st_reg_without_wb_v: got ST_REG=1 WB_V=0 expected ST_REG=0");
            end
            if (WB_V) begin
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_retire: got WB_V=1 DR=%0d expected no retire", DR);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("st_reg", 64'(ST_REG), 64'(e.st));
                    chk("instret", INSTRET, e.instret);
                    chk("load_err", 64'(LOAD_ERR), 64'(e.err));
                    if (e.st) begin
                        chk("dr", 64'(DR), 64'(e.dr));
                        chk("wb_data", WB_DATA, e.data);
                    end
                end
            end
        end
    end

    task automatic drive(input logic [4:0] dr, input logic we, input logic [1:0] sel,
                         input logic [2:0] f3, input logic [63:0] alu, input logic [63:0] pc);
        MEM_V = 1'b1; MEM_DR = dr; MEM_REG_WE = we; MEM_WB_SEL = sel;
        MEM_LD_FUNCT3 = f3; MEM_ALU_RESULT = alu; MEM_PC = pc;
        chk("ready_at_issue", 64'(WB_READY), 64'd1);
        @(posedge CLK); #1;
        MEM_V = 1'b0;
    endtask

    task automatic issue(input logic [4:0] dr, input logic we, input logic [1:0] sel,
                         input logic [63:0] alu, input logic [63:0] pc, input logic [63:0] exp_data);
        push_exp(we && dr != 5'd0, dr, exp_data);
        drive(dr, we, sel, 3'd0, alu, pc);
    endtask

    // Load whose data arrives on the delay-th WAIT_LOAD cycle
    task automatic do_load(input logic [4:0] dr, input logic [2:0] f3, input logic [63:0] addr,
                           input logic [63:0] rdata, input int delay, input logic [63:0] exp_data);
        push_exp(dr != 5'd0, dr, exp_data);
        drive(dr, 1'b1, 2'd1, f3, addr, 64'd0);
        for (int i = 1; i < delay; i++) begin
            chk("ready_low_in_load", 64'(WB_READY), 64'd0);
            @(posedge CLK); #1;
        end
        DMEM_RDATA = rdata; DMEM_RVALID = 1'b1;
        chk("ready_low_in_load", 64'(WB_READY), 64'd0);
        @(posedge CLK); #1;
        DMEM_RVALID = 1'b0;
        chk("ready_after_load", 64'(WB_READY), 64'd1);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_wb_ready", 64'(WB_READY), 64'd1);
        chk("rst_dr", 64'(DR), 64'd0);
        chk("rst_wb_data", WB_DATA, 64'd0);
        chk("rst_st_reg", 64'(ST_REG), 64'd0);
        chk("rst_wb_v", 64'(WB_V), 64'd0);
        chk("rst_instret", INSTRET, 64'd0);
        chk("rst_load_err", 64'(LOAD_ERR), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; MEM_V = 1'b0; MEM_DR = '0; MEM_REG_WE = 1'b0; MEM_WB_SEL = '0;
        MEM_LD_FUNCT3 = '0; MEM_ALU_RESULT = '0; MEM_PC = '0; DMEM_RDATA = '0; DMEM_RVALID = 1'b0;
        #1;
        chk_reset_outputs();
        repeat (2) @(posedge CLK);
        #3 reset = 1'b1;
        @(posedge CLK); #1;

        // ALU, PC+4 wrap, SEL=3 as ALU, WE=0, back-to-back
        issue(5'd5, 1'b1, 2'd0, 64'h1234, 64'h0, 64'h1234);
        issue(5'd1, 1'b1, 2'd2, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0);
        issue(5'd9, 1'b1, 2'd3, 64'hDEAD_0000_BEEF_0001, 64'h0, 64'hDEAD_0000_BEEF_0001);
        issue(5'd10, 1'b1, 2'd2, 64'h0, 64'h0000_0000_0000_1000, 64'h0000_0000_0000_1004);
        issue(5'd11, 1'b0, 2'd0, 64'h55, 64'h0, 64'h55);
        // x0 write retires without a register write
        issue(5'd0, 1'b1, 2'd0, 64'h7, 64'h0, 64'h7);
        @(posedge CLK); #1;

        // Load extension cases
        do_load(5'd7,  3'b000, 64'h1003, 64'h0000_0000_80FF_0000, 4, 64'hFFFF_FFFF_FFFF_FF80);
        do_load(5'd8,  3'b100, 64'h1003, 64'h0000_0000_80FF_0000, 2, 64'h0000_0000_0000_0080);
        do_load(5'd12, 3'b110, 64'h2004, 64'h8000_0001_0000_0000, 1, 64'h0000_0000_8000_0001);
        do_load(5'd13, 3'b001, 64'h0002, 64'h0000_0000_80FF_0000, 3, 64'hFFFF_FFFF_FFFF_80FF);
        do_load(5'd14, 3'b010, 64'h0000, 64'hDEAD_BEEF_8765_4321, 1, 64'hFFFF_FFFF_8765_4321);
        do_load(5'd15, 3'b011, 64'h0000, 64'hDEAD_BEEF_8765_4321, 2, 64'hDEAD_BEEF_8765_4321);
        do_load(5'd16, 3'b111, 64'h0005, 64'h1122_3344_5566_7788, 1, 64'h0000_0000_0011_2233);
        do_load(5'd17, 3'b101, 64'h0006, 64'h8001_0000_0000_0000, 1, 64'h0000_0000_0000_8001);
        // Accept in the cycle straight after a load return
        issue(5'd18, 1'b1, 2'd0, 64'hA5A5, 64'h0, 64'hA5A5);

        // Load timeout after 8 WAIT_LOAD cycles
        exp_err = 1'b1;
        push_exp(1'b0, 5'd19, 64'h0);
        drive(5'd19, 1'b1, 2'd1, 3'b011, 64'h0, 64'h0);
        for (int i = 0; i < 8; i++) begin
            chk("ready_low_timeout", 64'(WB_READY), 64'd0);
            @(posedge CLK); #1;
        end
        chk("ready_after_timeout", 64'(WB_READY), 64'd1);
        chk("load_err_set", 64'(LOAD_ERR), 64'd1);
        @(posedge CLK); #1;
        // Stray return while idle must not retire anything
        DMEM_RDATA = 64'hFFFF; DMEM_RVALID = 1'b1;
        @(posedge CLK); #1;
        DMEM_RVALID = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("load_err_sticky", 64'(LOAD_ERR), 64'd1);
        issue(5'd20, 1'b1, 2'd0, 64'h42, 64'h0, 64'h42);
        @(posedge CLK); #1;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        // Reset asserted mid-load
        drive(5'd21, 1'b1, 2'd1, 3'b011, 64'h0, 64'h0);
        @(posedge CLK); #2;
        reset = 1'b0;
        #1;
        chk_reset_outputs();
        exp_instret = 64'd0;
        exp_err     = 1'b0;
        #2 reset = 1'b1;
        @(posedge CLK); #1;
        DMEM_RDATA = 64'h1234_5678; DMEM_RVALID = 1'b1;
        @(posedge CLK); #1;
        DMEM_RVALID = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("no_write_after_reset", 64'(ST_REG), 64'd0);
        chk("instret_after_reset", INSTRET, 64'd0);
        issue(5'd3, 1'b1, 2'd0, 64'h99, 64'h0, 64'h99);
        repeat (2) @(posedge CLK);
        #1;
        chk("queue_drained_end", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
